// File: rtl/arm_rf_pkg.sv
// Shared definitions for the banked ARM register file: mode encodings, physical
// register layout and the logical-to-physical index function.
package arm_rf_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int NUM_PHYS = 30;

  typedef logic [4:0] phys_t;

  // r0-r7 occupy physical 0-7; banked copies follow in mode order.
  localparam phys_t PR_R8_USR  = 5'd8;
  localparam phys_t PR_R8_FIQ  = 5'd13;
  localparam phys_t PR_R13_USR = 5'd18;
  localparam phys_t PR_R13_FIQ = 5'd20;
  localparam phys_t PR_R13_IRQ = 5'd22;
  localparam phys_t PR_R13_SVC = 5'd24;
  localparam phys_t PR_R13_ABT = 5'd26;
  localparam phys_t PR_R13_UND = 5'd28;

  // Address 15 has no physical home; callers must use the separate r15 flag.
  function automatic phys_t phys_idx(input logic [4:0] mode, input logic usr_bank,
                                     input logic [3:0] addr);
    logic [4:0] m;
    phys_t      base;
    phys_t      r;
    m    = usr_bank ? MODE_USR : mode;
    r    = 5'd0;
    base = PR_R13_USR;
    if (addr < 4'd8) begin
      r = phys_t'(addr);
    end else if (addr <= 4'd12) begin
      r = ((m == MODE_FIQ) ? PR_R8_FIQ : PR_R8_USR) + phys_t'(addr) - 5'd8;
    end else if (addr != 4'd15) begin
      case (m)
        MODE_FIQ: base = PR_R13_FIQ;
        MODE_IRQ: base = PR_R13_IRQ;
        MODE_SVC: base = PR_R13_SVC;
        MODE_ABT: base = PR_R13_ABT;
        MODE_UND: base = PR_R13_UND;
        default:  base = PR_R13_USR;
      endcase
      r = base + phys_t'(addr == 4'd14);
    end
    return r;
  endfunction

endpackage

// File: rtl/arm_banked_rf_bank_map.sv
// Combinational logical-to-physical register index map with an r15 flag.
module rf_bank_map
  import arm_rf_pkg::*;
(
  input  logic [4:0] mode,
  input  logic       usr_bank,
  input  logic [3:0] addr,
  output phys_t      idx,
  output logic       is_pc
);

  assign idx   = phys_idx(mode, usr_bank, addr);
  assign is_pc = (addr == 4'hF);

endmodule

// File: rtl/arm_banked_rf.sv
// Banked ARM register file: 30 physical registers, NUM_RD combinational read
// ports, two write ports (port 1 wins on conflict), optional write-to-read bypass.
module arm_banked_rf
  import arm_rf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               mode,
  input  logic                     usr_bank,
  input  logic [NUM_RD*4-1:0]      ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     we0,
  input  logic [3:0]               wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [3:0]               wa1,
  input  logic [DATA_W-1:0]        wd1
);

  logic [DATA_W-1:0] regs [NUM_PHYS];

  phys_t wi0, wi1;
  logic  wpc0, wpc1;
  logic  wr0, wr1;

  rf_bank_map u_wmap0 (.mode(mode), .usr_bank(usr_bank), .addr(wa0), .idx(wi0), .is_pc(wpc0));
  rf_bank_map u_wmap1 (.mode(mode), .usr_bank(usr_bank), .addr(wa1), .idx(wi1), .is_pc(wpc1));

  assign wr0 = we0 && !wpc0;
  assign wr1 = we1 && !wpc1;

  // Port 1 is assigned last so it overrides port 0 on the same physical register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) regs[i] <= '0;
    end else begin
      if (wr0) regs[wi0] <= wd0;
      if (wr1) regs[wi1] <= wd1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    phys_t             ri;
    logic              rpc;
    logic [DATA_W-1:0] val;

    rf_bank_map u_rmap (.mode(mode), .usr_bank(usr_bank), .addr(ra[4*g +: 4]),
                        .idx(ri), .is_pc(rpc));

    // Bypass is not gated by rst: write data still forwards while storage is held clear.
    always_comb begin
      val = regs[ri];
      if (rpc) begin
        val = pc_in;
      end else if (BYPASS) begin
        if (wr1 && wi1 == ri)      val = wd1;
        else if (wr0 && wi0 == ri) val = wd0;
      end
    end

    assign rd[DATA_W*g +: DATA_W] = val;
  end

endmodule

// File: tb/tb_arm_banked_rf.sv
// Directed bench: two DUT copies (BYPASS=1 and BYPASS=0) share all inputs.
module tb_arm_banked_rf;
  import arm_rf_pkg::*;

  localparam int DW = 32;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       mode = MODE_USR;
  logic             usr_bank = 1'b0;
  logic [NR*4-1:0]  ra = '0;
  logic [NR*DW-1:0] rd_b, rd_n;
  logic [DW-1:0]    pc_in = 32'h1008;
  logic             we0 = 1'b0, we1 = 1'b0;
  logic [3:0]       wa0 = '0, wa1 = '0;
  logic [DW-1:0]    wd0 = '0, wd1 = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arm_banked_rf #(.DATA_W(DW), .NUM_RD(NR), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .mode(mode), .usr_bank(usr_bank), .ra(ra), .rd(rd_b),
    .pc_in(pc_in), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1));

  arm_banked_rf #(.DATA_W(DW), .NUM_RD(NR), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .mode(mode), .usr_bank(usr_bank), .ra(ra), .rd(rd_n),
    .pc_in(pc_in), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1));

  typedef struct {
    string       name;
    logic [4:0]  mode;
    logic        ub;
    logic [3:0]  ra0;
    logic        we0;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic [31:0] exp_b;
    logic [31:0] exp_n;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [4:0] md, input logic ub, input logic [3:0] r,
                     input logic e0, input logic [3:0] a0, input logic [31:0] d0,
                     input logic e1, input logic [3:0] a1, input logic [31:0] d1,
                     input logic [31:0] xb, input logic [31:0] xn);
    vec_t v;
    v.name = nm; v.mode = md; v.ub = ub; v.ra0 = r;
    v.we0 = e0; v.wa0 = a0; v.wd0 = d0; v.we1 = e1; v.wa1 = a1; v.wd1 = d1;
    v.exp_b = xb; v.exp_n = xn;
    vecs.push_back(v);
  endtask

  initial begin
    // name              mode      ub  ra  we0 wa0  wd0            we1 wa1  wd1    exp_byp        exp_nobyp
    add("usr_wr_r8",     MODE_USR, 0,  8,  1,  8,   32'hAAAA0008,  0,  0,   0,     32'hAAAA0008,  32'h0);
    add("fiq_wr_r8",     MODE_FIQ, 0,  8,  1,  8,   32'h5555F008,  0,  0,   0,     32'h5555F008,  32'h0);
    add("fiq_rd_r8",     MODE_FIQ, 0,  8,  0,  0,   0,             0,  0,   0,     32'h5555F008,  32'h5555F008);
    add("usr_rd_r8",     MODE_USR, 0,  8,  0,  0,   0,             0,  0,   0,     32'hAAAA0008,  32'hAAAA0008);
    add("fiq_wr_r0",     MODE_FIQ, 0,  0,  1,  0,   32'h77,        0,  0,   0,     32'h77,        32'h0);
    add("svc_rd_r0",     MODE_SVC, 0,  0,  0,  0,   0,             0,  0,   0,     32'h77,        32'h77);
    add("svc_wr_sp",     MODE_SVC, 0,  13, 1,  13,  32'h8000,      0,  0,   0,     32'h8000,      32'h0);
    add("irq_wr_sp",     MODE_IRQ, 0,  13, 1,  13,  32'h7000,      0,  0,   0,     32'h7000,      32'h0);
    add("usr_wr_sp",     MODE_USR, 0,  13, 1,  13,  32'h6000,      0,  0,   0,     32'h6000,      32'h0);
    add("svc_rd_sp",     MODE_SVC, 0,  13, 0,  0,   0,             0,  0,   0,     32'h8000,      32'h8000);
    add("irq_rd_sp",     MODE_IRQ, 0,  13, 0,  0,   0,             0,  0,   0,     32'h7000,      32'h7000);
    add("usr_rd_sp",     MODE_USR, 0,  13, 0,  0,   0,             0,  0,   0,     32'h6000,      32'h6000);
    add("sys_rd_sp",     MODE_SYS, 0,  13, 0,  0,   0,             0,  0,   0,     32'h6000,      32'h6000);
    add("fiq_rd_sp",     MODE_FIQ, 0,  13, 0,  0,   0,             0,  0,   0,     32'h0,         32'h0);
    add("svc_ub_rd_sp",  MODE_SVC, 1,  13, 0,  0,   0,             0,  0,   0,     32'h6000,      32'h6000);
    add("svc_ub_wr_sp",  MODE_SVC, 1,  13, 1,  13,  32'h6100,      0,  0,   0,     32'h6100,      32'h6000);
    add("svc_sp_kept",   MODE_SVC, 0,  13, 0,  0,   0,             0,  0,   0,     32'h8000,      32'h8000);
    add("usr_sp_new",    MODE_USR, 0,  13, 0,  0,   0,             0,  0,   0,     32'h6100,      32'h6100);
    add("abt_wr_lr",     MODE_ABT, 0,  14, 1,  14,  32'hAB,        0,  0,   0,     32'hAB,        32'h0);
    add("und_rd_lr",     MODE_UND, 0,  14, 0,  0,   0,             0,  0,   0,     32'h0,         32'h0);
    add("und_wr_lr",     MODE_UND, 0,  14, 1,  14,  32'hCD,        0,  0,   0,     32'hCD,        32'h0);
    add("abt_rd_lr",     MODE_ABT, 0,  14, 0,  0,   0,             0,  0,   0,     32'hAB,        32'hAB);
    add("dual_same",     MODE_USR, 0,  3,  1,  3,   32'h11,        1,  3,   32'h22, 32'h22,       32'h0);
    add("dual_same_rd",  MODE_USR, 0,  3,  0,  0,   0,             0,  0,   0,     32'h22,        32'h22);
    add("dual_diff",     MODE_USR, 0,  3,  1,  3,   32'h11,        1,  4,   32'h22, 32'h11,       32'h22);
    add("dual_diff_r3",  MODE_USR, 0,  3,  0,  0,   0,             0,  0,   0,     32'h11,        32'h11);
    add("dual_diff_r4",  MODE_USR, 0,  4,  0,  0,   0,             0,  0,   0,     32'h22,        32'h22);
    add("byp_r5",        MODE_USR, 0,  5,  1,  5,   32'hDEAD,      0,  0,   0,     32'hDEAD,      32'h0);
    add("byp_r5_next",   MODE_USR, 0,  5,  0,  0,   0,             0,  0,   0,     32'hDEAD,      32'hDEAD);
    add("wr15_r0",       MODE_USR, 0,  0,  1,  15,  32'hBEEF,      1,  15,  32'hBEE1, 32'h77,     32'h77);
    add("wr15_pc",       MODE_USR, 0,  15, 1,  15,  32'hBEEF,      0,  0,   0,     32'h1008,      32'h1008);
    add("wr15_r0_after", MODE_USR, 0,  0,  0,  0,   0,             0,  0,   0,     32'h77,        32'h77);
    add("m0_rd_sp",      5'b00000, 0,  13, 0,  0,   0,             0,  0,   0,     32'h6100,      32'h6100);
    add("m0_wr_r9",      5'b00000, 0,  9,  1,  9,   32'h99,        0,  0,   0,     32'h99,        32'h0);
    add("usr_rd_r9",     MODE_USR, 0,  9,  0,  0,   0,             0,  0,   0,     32'h99,        32'h99);
    add("fiq_rd_r9",     MODE_FIQ, 0,  9,  0,  0,   0,             0,  0,   0,     32'h0,         32'h0);

    // Reset pulse mid-cycle, then read three ports and the PC.
    ra = {4'd14, 4'd7, 4'd0};
    #2 rst = 1'b1;
    #1;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rst_byp_p%0d", p), rd_b[DW*p +: DW], 32'h0);
      check($sformatf("rst_nob_p%0d", p), rd_n[DW*p +: DW], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    ra = {4'd15, 4'd15, 4'd15};
    #2;
    check("rst_pc_p0", rd_b[DW-1:0], 32'h1008);
    check("rst_pc_p2", rd_n[DW*2 +: DW], 32'h1008);

    foreach (vecs[i]) begin
      @(negedge clk);
      mode = vecs[i].mode; usr_bank = vecs[i].ub; ra = {4'd0, 4'd0, vecs[i].ra0};
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      #2;
      check({vecs[i].name, "_byp"}, rd_b[DW-1:0], vecs[i].exp_b);
      check({vecs[i].name, "_nob"}, rd_n[DW-1:0], vecs[i].exp_n);
    end

    // Async reset mid-operation: stored r2 cleared at once, pending write lost.
    @(negedge clk);
    mode = MODE_USR; usr_bank = 1'b0; ra = {4'd0, 4'd0, 4'd2};
    we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h1234; we1 = 1'b0;
    @(negedge clk);
    we0 = 1'b0;
    #1 check("r2_written", rd_n[DW-1:0], 32'h1234);
    #1 we0 = 1'b1; wd0 = 32'h99; rst = 1'b1;
    #1;
    check("rst_mid_nob", rd_n[DW-1:0], 32'h0);
    check("rst_mid_byp", rd_b[DW-1:0], 32'h99);
    @(posedge clk);
    #1 check("rst_hold_nob", rd_n[DW-1:0], 32'h0);
    @(negedge clk);
    rst = 1'b0; we0 = 1'b0;
    #2;
    check("rst_rel_nob", rd_n[DW-1:0], 32'h0);
    check("rst_rel_byp", rd_b[DW-1:0], 32'h0);
    @(posedge clk);
    #1 check("rst_rel_edge", rd_b[DW-1:0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
